cc_bus_sequencer: RTL and testbench
===================================

// Module: cc_bus_sequencer
// PURPOSE
//  Initiator for the cc control bus. Takes one byte command per valid/ready handshake,
//  drives it onto the 21-bit cc input vector as a timed SETUP/STROBE/SAMPLE/RECOVER sequence,
//  captures the 8-bit response lane that the combinational cc decoder returns (po12..po19),
//  and hands that response back as a one-cycle pulse. Sits between the host command FIFO and the cc decoder.
// PARAMETERS
//  SETUP_CYC  2  cycles bus is held stable before strobe (>=1)
//  STB_CYC    1  STROBE-state cycles before SAMPLE (>=1)
//  REC_CYC    1  RECOVER-state cycles, bus idle, before next accept (>=1)
//  CNT_W      4  phase counter width; must hold max(SETUP_CYC,STB_CYC,REC_CYC)-1
// PORTS
//  clk        in   1  single clock, all state on rising edge
//  rst        in   1  synchronous, active-high reset
//  cmd_valid  in   1  command offered
//  cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at clk edge
//  cmd_data   in   8  data byte -> bus_data (pi00..pi07)
//  cmd_mode   in   2  [1]=dir -> bus_dir (pi15), [0]=inhibit -> bus_inh (pi14)
//  bus_data   out  8  pi00..pi07
//  bus_en     out  1  pi08, transaction enable
//  bus_par    out  1  pi09, even parity = ^cmd_data
//  bus_sel    out  1  pi10, select
//  bus_stb    out  1  pi12, strobe
//  bus_inh    out  1  pi14
//  bus_dir    out  1  pi15
//  resp_in    in   8  po12..po19 from cc decoder
//  resp_valid out  1  one-cycle pulse, resp_data valid
//  resp_data  out  8  captured resp_in, held until next capture
//  busy       out  1  state != IDLE
// BEHAVIOUR
//  - All outputs are registered. Reset: state=IDLE, cmd_ready=0, every bus_* output=0,
//    resp_valid=0, resp_data=0, busy=0. cmd_ready rises one cycle after rst deasserts.
//  - FSM IDLE -> SETUP -> STROBE -> SAMPLE -> RECOVER -> IDLE.
//  - IDLE: cmd_ready=1. On accept, latch cmd_data/cmd_mode and compute parity; go to SETUP.
//  - SETUP: SETUP_CYC cycles. en=sel=1; data, par, inh and dir driven; stb=0.
//  - STROBE: STB_CYC cycles. As SETUP, plus stb=1.
//  - SAMPLE: 1 cycle, stb still 1. resp_data <= resp_in at the closing edge;
//    resp_valid=1 in the following cycle, which is the first RECOVER cycle.
//  - RECOVER: REC_CYC cycles. All bus_* outputs=0. Return to IDLE.
//  - Phase counter loads (N-1) on state entry and decrements; leave the state at 0. No wrap.
//  - Timing with defaults: accept edge t0; SETUP t1-t2; STROBE t3; SAMPLE t4;
//    resp_valid t5; IDLE with cmd_ready=1 at t6.
//    Max throughput is one command per SETUP_CYC+STB_CYC+REC_CYC+2 cycles.
//  - cmd_ready=0 outside IDLE. cmd_valid outside IDLE is ignored and not queued.
//  - cmd_valid dropping mid-transaction has no effect; a started sequence always completes.
//  - resp_in is sampled only in SAMPLE. Changes at any other time do not alter resp_data.
//  - rst mid-transaction (any state) forces the reset values at that edge.
//    No resp_valid is produced for an aborted command.
//  - rst and cmd_valid in the same cycle: rst wins; the command is not accepted.
// STRUCTURE
//  - cc_pkg holds: the state enum (IDLE,SETUP,STROBE,SAMPLE,RECOVER), the cmd_mode bit
//    indices, and localparams mapping each bus_* signal to its pi index (0..7, 8, 9, 10, 12, 14, 15).
//  - One sub-module, cc_phase_counter (load, dec, zero flag, CNT_W wide).
//    The FSM and output registers live in the top module.
// TESTING
//  1. rst held 3 cycles, then released -> all outputs 0 during rst;
//     cmd_ready=1 on the first cycle after release.
//  2. Defaults, cmd_data=0xA5, mode=2'b10 -> bus_data=0xA5, par=0, dir=1, inh=0 in t1-t4;
//     stb=1 only in t3-t4; resp_in=0x5A at t4 -> resp_valid pulse at t5 with resp_data=0x5A.
//  3. Back-to-back commands, cmd_valid held high -> accepts exactly 6 cycles apart;
//     cmd_ready=0 for t1-t5.
//  4. resp_in toggled to 0xFF everywhere except SAMPLE (0x00 there) -> resp_data=0x00.
//  5. rst asserted during STROBE -> next cycle all bus_* outputs=0; no resp_valid;
//     new command accepted normally afterwards.
//  6. SETUP_CYC=4, STB_CYC=3, REC_CYC=2, cmd_data=0x01 -> par=1;
//     stb high for exactly 4 cycles; accept-to-accept period is 11 cycles.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared types and bit maps for the cc bus sequencer: FSM states, cmd_mode bit
// positions, and where each bus_* signal lands on the cc decoder's pi vector.
package cc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        SAMPLE,
        RECOVER
    } cc_state_t;

    localparam int MODE_INH_BIT = 0;
    localparam int MODE_DIR_BIT = 1;

    localparam int PI_W       = 21;
    localparam int PI_DATA_LO = 0;
    localparam int PI_DATA_HI = 7;
    localparam int PI_EN      = 8;
    localparam int PI_PAR     = 9;
    localparam int PI_SEL     = 10;
    localparam int PI_STB     = 12;
    localparam int PI_INH     = 14;
    localparam int PI_DIR     = 15;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    // Places the bus_* signals at their pi positions; unused pi bits stay 0.
    function automatic logic [PI_W-1:0] pack_pi(
        input logic [7:0] data,
        input logic       en,
        input logic       par,
        input logic       sel,
        input logic       stb,
        input logic       inh,
        input logic       dir
    );
        logic [PI_W-1:0] pi;
        pi = '0;
        pi[PI_DATA_HI:PI_DATA_LO] = data;
        pi[PI_EN]  = en;
        pi[PI_PAR] = par;
        pi[PI_SEL] = sel;
        pi[PI_STB] = stb;
        pi[PI_INH] = inh;
        pi[PI_DIR] = dir;
        return pi;
    endfunction

endpackage

// File: rtl/cc_bus_sequencer_if.sv
// Host-command, cc-bus and response signals of the cc bus sequencer, bundled
// with a master modport (the sequencer) and a slave modport (host + decoder side).
interface cc_bus_sequencer_if;
    import cc_pkg::*;

    // Handshake: a command transfers at a rising edge where cmd_valid and
    // cmd_ready are both 1; cmd_ready is only ever 1 in IDLE and nothing is
    // queued while it is 0. resp_valid is a one-cycle pulse with no back-pressure.
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [1:0] cmd_mode;

    logic [7:0] bus_data;
    logic       bus_en;
    logic       bus_par;
    logic       bus_sel;
    logic       bus_stb;
    logic       bus_inh;
    logic       bus_dir;

    logic [7:0] resp_in;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       busy;

    cc_state_t  state;

    modport master (
        input  cmd_valid, cmd_data, cmd_mode, resp_in,
        output cmd_ready, bus_data, bus_en, bus_par, bus_sel, bus_stb,
               bus_inh, bus_dir, resp_valid, resp_data, busy, state
    );

    modport slave (
        output cmd_valid, cmd_data, cmd_mode, resp_in,
        input  cmd_ready, bus_data, bus_en, bus_par, bus_sel, bus_stb,
               bus_inh, bus_dir, resp_valid, resp_data, busy, state
    );

endinterface

// File: rtl/cc_phase_counter.sv
// Down-counter timing each FSM phase: loaded with (N-1) on state entry,
// decremented while the phase lasts, saturating at zero.
module cc_phase_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cc_bus_sequencer.sv
// cc control bus initiator: accepts one command byte, runs SETUP/STROBE/SAMPLE/
// RECOVER on the cc input vector and returns the decoder's response as a pulse.
module cc_bus_sequencer
    import cc_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int STB_CYC   = 1,
    parameter int REC_CYC   = 1,
    parameter int CNT_W     = 4
) (
    input logic                clk,
    input logic                rst,
    cc_bus_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STB_LD   = CNT_W'(STB_CYC - 1);
    localparam logic [CNT_W-1:0] REC_LD   = CNT_W'(REC_CYC - 1);

    cc_state_t        state;
    cc_state_t        next_state;
    logic             accept;
    logic             drive;
    logic             ph_load;
    logic             ph_dec;
    logic             ph_zero;
    logic [CNT_W-1:0] ph_val;

    assign accept = bus.cmd_valid & bus.cmd_ready & (state == IDLE);

    cc_phase_counter #(.CNT_W(CNT_W)) u_phase (
        .clk      (clk),
        .rst      (rst),
        .load     (ph_load),
        .dec      (ph_dec),
        .load_val (ph_val),
        .zero     (ph_zero)
    );

    always_comb begin
        next_state = state;
        ph_load    = 1'b0;
        ph_dec     = 1'b0;
        ph_val     = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SETUP;
                    ph_load    = 1'b1;
                    ph_val     = SETUP_LD;
                end
            end
            SETUP: begin
                if (ph_zero) begin
                    next_state = STROBE;
                    ph_load    = 1'b1;
                    ph_val     = STB_LD;
                end else begin
                    ph_dec = 1'b1;
                end
            end
            STROBE: begin
                if (ph_zero) begin
                    next_state = SAMPLE;
                end else begin
                    ph_dec = 1'b1;
                end
            end
            SAMPLE: begin
                next_state = RECOVER;
                ph_load    = 1'b1;
                ph_val     = REC_LD;
            end
            RECOVER: begin
                if (ph_zero) begin
                    next_state = IDLE;
                end else begin
                    ph_dec = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    assign drive = next_state inside {SETUP, STROBE, SAMPLE};

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.cmd_ready  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.bus_data   <= '0;
            bus.bus_en     <= 1'b0;
            bus.bus_par    <= 1'b0;
            bus.bus_sel    <= 1'b0;
            bus.bus_stb    <= 1'b0;
            bus.bus_inh    <= 1'b0;
            bus.bus_dir    <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
        end else begin
            state         <= next_state;
            bus.cmd_ready <= (next_state == IDLE);
            bus.busy      <= (next_state != IDLE);
            bus.bus_en    <= drive;
            bus.bus_sel   <= drive;
            bus.bus_stb   <= next_state inside {STROBE, SAMPLE};
            if (accept) begin
                bus.bus_data <= bus.cmd_data;
                bus.bus_par  <= even_parity(bus.cmd_data);
                bus.bus_inh  <= bus.cmd_mode[MODE_INH_BIT];
                bus.bus_dir  <= bus.cmd_mode[MODE_DIR_BIT];
            end else if (!drive) begin
                bus.bus_data <= '0;
                bus.bus_par  <= 1'b0;
                bus.bus_inh  <= 1'b0;
                bus.bus_dir  <= 1'b0;
            end
            bus.resp_valid <= (state == SAMPLE);
            if (state == SAMPLE) begin
                bus.resp_data <= bus.resp_in;
            end
        end
    end

    assign bus.state = state;

endmodule

// File: tb/tb_cc_bus_sequencer.sv
// Bench for cc_bus_sequencer: cycle vector table on a default-parameter instance,
// then back-to-back, abort and long-phase sequences.
module tb_cc_bus_sequencer;
    import cc_pkg::*;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [7:0]  data;
        logic [1:0]  mode;
        logic [7:0]  resp;
        logic [24:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    cc_bus_sequencer_if if0 ();
    cc_bus_sequencer_if if6 ();

    cc_bus_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    cc_bus_sequencer #(
        .SETUP_CYC (4),
        .STB_CYC   (3),
        .REC_CYC   (2),
        .CNT_W     (4)
    ) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (if6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] ow(input logic rdy, input logic [7:0] d,
                                       input logic en, input logic par, input logic sel,
                                       input logic stb, input logic inh, input logic dir,
                                       input logic rv, input logic [7:0] rd, input logic bsy);
        return {rdy, d, en, par, sel, stb, inh, dir, rv, rd, bsy};
    endfunction

    function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                                input logic [1:0] m, input logic [7:0] rs, input logic [24:0] e);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.mode = m; x.resp = rs; x.exp = e;
        return x;
    endfunction

    function automatic logic [24:0] out0();
        return {if0.cmd_ready, if0.bus_data, if0.bus_en, if0.bus_par, if0.bus_sel,
                if0.bus_stb, if0.bus_inh, if0.bus_dir, if0.resp_valid, if0.resp_data, if0.busy};
    endfunction

    task automatic run_cmd(input logic [7:0] d, input logic [1:0] m, input logic [7:0] r,
                           input string tag);
        int n;
        n = 0;
        while (!if0.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(if0.cmd_ready), 32'd1);
        if0.cmd_valid = 1'b1;
        if0.cmd_data  = d;
        if0.cmd_mode  = m;
        tick();
        if0.cmd_valid = 1'b0;
        check({tag, "_setup"}, 32'({if0.bus_data, if0.bus_par, if0.bus_inh, if0.bus_dir}),
              32'({d, ^d, m[0], m[1]}));
        tick();
        tick();
        tick();
        if0.resp_in = r;
        tick();
        if0.resp_in = ~r;
        check({tag, "_resp"}, 32'({if0.resp_valid, if0.resp_data}), 32'({1'b1, r}));
    endtask

    initial begin
        vec_t vecs[$];
        int   last;
        int   acc;
        int   cnt;

        rst = 1'b1;
        if0.cmd_valid = 1'b0; if0.cmd_data = '0; if0.cmd_mode = '0; if0.resp_in = '0;
        if6.cmd_valid = 1'b0; if6.cmd_data = '0; if6.cmd_mode = '0; if6.resp_in = '0;

        // Reset, one A5/dir command with response 5A, then 07/inh with 00 captured
        // while resp_in sits at FF in every other cycle, then rst against cmd_valid.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1'b1, 1'b0, 8'h00, 2'b00, 8'h00,
                ow(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0)));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 2'b00, 8'h00,
            ow(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0)));
        vecs.push_back(mk(1'b0, 1'b1, 8'hA5, 2'b10, 8'hFF,
            ow(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1)));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 2'b00, 8'hFF,
            ow(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1)));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(1'b0, 1'b0, 8'h00, 2'b00, 8'hFF,
                ow(1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1)));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 2'b00, 8'h5A,
            ow(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1)));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 2'b00, 8'hFF,
            ow(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0)));
        vecs.push_back(mk(1'b0, 1'b1, 8'h07, 2'b01, 8'hFF,
            ow(1'b0, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1)));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 2'b00, 8'hFF,
            ow(1'b0, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1)));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(1'b0, 1'b0, 8'h00, 2'b00, 8'hFF,
                ow(1'b0, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1)));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 2'b00, 8'h00,
            ow(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1)));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 2'b00, 8'hFF,
            ow(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0)));
        vecs.push_back(mk(1'b1, 1'b1, 8'hE1, 2'b11, 8'hFF,
            ow(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0)));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 2'b00, 8'hFF,
            ow(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0)));

        for (int i = 0; i < vecs.size(); i++) begin
            rst           = vecs[i].rst;
            if0.cmd_valid = vecs[i].valid;
            if0.cmd_data  = vecs[i].data;
            if0.cmd_mode  = vecs[i].mode;
            if0.resp_in   = vecs[i].resp;
            tick();
            check($sformatf("vec%0d", i), 32'(out0()), 32'(vecs[i].exp));
        end

        // Back-to-back with cmd_valid held high; response = resp_in of the SAMPLE cycle.
        last = -1;
        acc  = 0;
        for (int c = 0; c < 20; c++) begin
            if0.cmd_valid = (c < 13);
            if0.cmd_data  = 8'(c + 16);
            if0.cmd_mode  = 2'(c);
            if0.resp_in   = 8'(c * 13 + 5);
            if (if0.resp_valid) begin
                if (exp_q.size() == 0) check("b2b_extra_resp", 32'd1, 32'd0);
                else check("b2b_resp", 32'(if0.resp_data), 32'(exp_q.pop_front()));
            end
            if (if0.cmd_ready && if0.cmd_valid) begin
                if (last >= 0) check("b2b_period", 32'(c - last), 32'd6);
                last = c;
                acc++;
                exp_q.push_back(8'((c + 4) * 13 + 5));
            end
            tick();
        end
        check("b2b_accepts", 32'(acc), 32'd3);
        check("b2b_drain", 32'(exp_q.size()), 32'd0);

        // Reset during STROBE aborts the command without a response.
        if0.cmd_valid = 1'b1;
        if0.cmd_data  = 8'h3C;
        if0.cmd_mode  = 2'b11;
        if0.resp_in   = 8'h77;
        tick();
        if0.cmd_valid = 1'b0;
        tick();
        tick();
        check("abort_in_strobe", 32'({if0.bus_stb, if0.busy}), 32'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outputs", 32'(out0()), 32'(25'd0));
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (if0.resp_valid) cnt++;
        end
        check("abort_no_resp", 32'(cnt), 32'd0);
        run_cmd(8'hC3, 2'b01, 8'h96, "after_abort");

        // Long phases: SETUP 4, STROBE 3, REC 2.
        last = -1;
        acc  = 0;
        cnt  = 0;
        for (int c = 0; c < 25; c++) begin
            if6.cmd_valid = (c < 12);
            if6.cmd_data  = 8'h01;
            if6.cmd_mode  = 2'b00;
            if6.resp_in   = 8'(c + 64);
            if (c >= 1 && c <= 11 && if6.bus_stb) cnt++;
            if (c == 1) check("p6_par", 32'(if6.bus_par), 32'd1);
            if (if6.resp_valid) begin
                if (exp_q.size() == 0) check("p6_extra_resp", 32'd1, 32'd0);
                else check("p6_resp", 32'(if6.resp_data), 32'(exp_q.pop_front()));
            end
            if (if6.cmd_ready && if6.cmd_valid) begin
                if (last >= 0) check("p6_period", 32'(c - last), 32'd11);
                last = c;
                acc++;
                exp_q.push_back(8'(c + 8 + 64));
            end
            tick();
        end
        check("p6_stb_cycles", 32'(cnt), 32'd4);
        check("p6_accepts", 32'(acc), 32'd2);
        check("p6_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
